fp8_add_arbiter: RTL

- Round-robin arbiter and sequencer that shares one multi-cycle 8-bit floating-point adder between N_REQ requesters.
- The FP8 format is: sign [7], exponent [6:4], fraction [3:0] with a hidden leading 1.
- The block accepts one operand pair at a time, drives the adder's start/done handshake, and returns the result to the granted requester.
- It sits between the requesting datapath blocks and the single FP8 adder instance.

---
 rtl/fp8_add_arbiter_pkg.sv | 13 +
 rtl/fp8_add_arbiter_if.sv | 30 +++
 rtl/fp8_add_arbiter_rr_pick.sv | 30 +++
 rtl/fp8_add_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/fp8_add_arbiter_pkg.sv
// Shared FP8 field positions and the arbiter state encoding.
package fp8_pkg;

   localparam int FP8_W    = 8;
   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 4;
   localparam int FRAC_MSB = 3;
   localparam int FRAC_LSB = 0;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

endpackage

// File: rtl/fp8_add_arbiter_if.sv
// Requester and adder-side signal bundle for fp8_add_arbiter.
interface fp8_add_arbiter_if import fp8_pkg::*; #(parameter int N_REQ = 4) ();

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0][FP8_W-1:0] req_op1;
   logic [N_REQ-1:0][FP8_W-1:0] req_op2;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0]            resp_valid;
   logic [FP8_W-1:0]            resp_res;
   logic                        resp_err;
   logic                        busy;
   logic                        fpu_start;
   logic [FP8_W-1:0]            fpu_op1;
   logic [FP8_W-1:0]            fpu_op2;
   logic                        fpu_done;
   logic [FP8_W-1:0]            fpu_res;

   modport slave (
      input  req_valid, req_op1, req_op2, fpu_done, fpu_res,
      output req_ready, resp_valid, resp_res, resp_err, busy,
             fpu_start, fpu_op1, fpu_op2
   );

   modport master (
      output req_valid, req_op1, req_op2, fpu_done, fpu_res,
      input  req_ready, resp_valid, resp_res, resp_err, busy,
             fpu_start, fpu_op1, fpu_op2
   );

endinterface

// File: rtl/fp8_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module fp8_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   int pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = (int'(last_grant) + k) % N_REQ;
         if (!any && req[pos]) begin
            any        = 1'b1;
            idx        = ID_W'(pos);
            grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp8_add_arbiter.sv
// Shares one multi-cycle FP8 adder among N_REQ requesters with round-robin grants.
// Define FP8_ARB_TIMEOUT_EN to abandon an adder op after TIMEOUT WAIT cycles (resp_err=1).
module fp8_add_arbiter import fp8_pkg::*; #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   fp8_add_arbiter_if.slave bus
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_t       state, state_nxt;
   logic [ID_W-1:0]  last_grant, owner, pick_idx;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_any;
   logic [FP8_W-1:0] op1_q, op2_q, res_q;
   logic             timed_out;

   fp8_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .grant      (pick_gnt),
      .idx        (pick_idx),
      .any        (pick_any)
   );

`ifdef FP8_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Counts WAIT cycles only; any other state holds it at zero so each WAIT starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                wait_cnt <= '0;
      else if (state != WAIT) wait_cnt <= '0;
      else                    wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      err_q <= 1'b0;
      else if (state == WAIT && bus.fpu_done)       err_q <= 1'b0;
      else if (state == WAIT && timed_out)          err_q <= 1'b1;
   end
`else
   logic unused_timeout;
   assign timed_out      = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_any) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (bus.fpu_done || timed_out) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= ID_W'(N_REQ - 1);
         owner      <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         res_q      <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: if (pick_any) begin
               owner <= pick_idx;
               op1_q <= bus.req_op1[pick_idx];
               op2_q <= bus.req_op2[pick_idx];
            end
            WAIT: begin
               if (bus.fpu_done)   res_q <= bus.fpu_res;
               else if (timed_out) res_q <= '0;
            end
            RESP:    last_grant <= owner;
            default: ;
         endcase
      end
   end

   // req_ready is gated by rst so every output reads 0 while reset is held.
   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.resp_res   = '0;
      bus.resp_err   = 1'b0;
      bus.fpu_start  = 1'b0;
      bus.fpu_op1    = op1_q;
      bus.fpu_op2    = op2_q;
      bus.busy       = (state != IDLE);
      unique case (state)
         IDLE:  if (!rst) bus.req_ready = pick_gnt;
         ISSUE: bus.fpu_start = 1'b1;
         RESP: begin
            bus.resp_valid[owner] = 1'b1;
            bus.resp_res          = res_q;
`ifdef FP8_ARB_TIMEOUT_EN
            bus.resp_err          = err_q;
`endif
         end
         default: ;
      endcase
   end

endmodule
